forwarding_scoreboard: RTL and testbench



---
 rtl/forwarding_scoreboard.sv | 147 ++++++++++++++
 tb/tb_forwarding_scoreboard.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/forwarding_scoreboard.sv
// Destination-register scoreboard: tracks in-flight writes across pipeline slots,
// forwards operands to read ports and drives the register-file write port at retirement.
module forwarding_scoreboard #(
    parameter int XLEN           = 32,
    parameter int NUM_STAGES     = 3,
    parameter int NUM_READ_PORTS = 2,
    parameter int NUM_FILL_PORTS = 2,
    localparam int SW            = (NUM_STAGES <= 2) ? 1 : $clog2(NUM_STAGES)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             advance,
    input  logic                             alloc_enable,
    input  logic [4:0]                       alloc_rd,
    input  logic [NUM_FILL_PORTS-1:0]        fill_valid,
    input  logic [NUM_FILL_PORTS*SW-1:0]     fill_slot,
    input  logic [NUM_FILL_PORTS*XLEN-1:0]   fill_value,
    input  logic [NUM_STAGES-1:0]            flush_mask,
    input  logic [NUM_READ_PORTS*5-1:0]      rs,
    input  logic [NUM_READ_PORTS-1:0]        rs_used,
    input  logic [NUM_READ_PORTS*XLEN-1:0]   rs_value,
    output logic [NUM_READ_PORTS*XLEN-1:0]   operand_value,
    output logic [NUM_READ_PORTS-1:0]        operand_valid,
    output logic                             stall,
    output logic                             retire_valid,
    output logic [4:0]                       retire_rd,
    output logic [XLEN-1:0]                  retire_value,
    output logic                             protocol_error
);

    localparam int LAST = NUM_STAGES - 1;

    logic [NUM_STAGES-1:0] slot_valid;
    logic [NUM_STAGES-1:0] slot_ready;
    logic [4:0]            slot_rd    [NUM_STAGES];
    logic [XLEN-1:0]       slot_value [NUM_STAGES];

    logic [NUM_STAGES-1:0] fill_hit;
    logic [NUM_STAGES-1:0] fill_eff;
    logic [XLEN-1:0]       fill_data  [NUM_STAGES];

    // Slot contents after this cycle's fills and flushes, before any shift.
    logic [NUM_STAGES-1:0] app_valid;
    logic [NUM_STAGES-1:0] app_ready;
    logic [XLEN-1:0]       app_value  [NUM_STAGES];

    logic                  drop;

    // Ascending port order lets the highest-numbered fill port win a shared slot.
    always_comb begin
        fill_hit = '0;
        fill_eff = '0;
        for (int unsigned s = 0; s < NUM_STAGES; s++) begin
            fill_data[s] = '0;
            for (int unsigned p = 0; p < NUM_FILL_PORTS; p++) begin
                if (fill_valid[p] && fill_slot[p*SW +: SW] == SW'(s)) begin
                    fill_hit[s]  = 1'b1;
                    fill_data[s] = fill_value[p*XLEN +: XLEN];
                end
            end
            fill_eff[s]  = fill_hit[s] & slot_valid[s] & ~flush_mask[s];
            app_valid[s] = slot_valid[s] & ~flush_mask[s];
            app_ready[s] = slot_ready[s] | fill_eff[s];
            app_value[s] = fill_eff[s] ? fill_data[s] : slot_value[s];
        end
    end

    always_comb begin
        retire_valid = advance & app_valid[LAST] & app_ready[LAST];
        retire_rd    = retire_valid ? slot_rd[LAST] : '0;
        retire_value = retire_valid ? app_value[LAST] : '0;
        drop         = advance & app_valid[LAST] & ~app_ready[LAST];
    end

    // Lowest-index match is the youngest producer of that register.
    always_comb begin
        logic [4:0]      r;
        logic            found;
        logic            sel_ready;
        logic            sel_fill;
        logic [XLEN-1:0] sel_value;
        logic [XLEN-1:0] sel_fdata;
        operand_value = '0;
        operand_valid = '0;
        for (int unsigned p = 0; p < NUM_READ_PORTS; p++) begin
            r         = rs[p*5 +: 5];
            found     = 1'b0;
            sel_ready = 1'b0;
            sel_fill  = 1'b0;
            sel_value = '0;
            sel_fdata = '0;
            for (int unsigned s = 0; s < NUM_STAGES; s++) begin
                if (!found && app_valid[s] && slot_rd[s] == r) begin
                    found     = 1'b1;
                    sel_ready = slot_ready[s];
                    sel_fill  = fill_eff[s];
                    sel_value = slot_value[s];
                    sel_fdata = fill_data[s];
                end
            end
            if (r == 5'd0 || !found) begin
                operand_valid[p]               = 1'b1;
                operand_value[p*XLEN +: XLEN]  = rs_value[p*XLEN +: XLEN];
            end else if (sel_ready) begin
                operand_valid[p]               = 1'b1;
                operand_value[p*XLEN +: XLEN]  = sel_value;
            end else if (sel_fill) begin
                operand_valid[p]               = 1'b1;
                operand_value[p*XLEN +: XLEN]  = sel_fdata;
            end
        end
        stall = |(rs_used & ~operand_valid);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_valid     <= '0;
            slot_ready     <= '0;
            protocol_error <= 1'b0;
            for (int unsigned s = 0; s < NUM_STAGES; s++) begin
                slot_rd[s]    <= '0;
                slot_value[s] <= '0;
            end
        end else begin
            protocol_error <= protocol_error | drop;
            if (advance) begin
                slot_valid[0] <= alloc_enable && alloc_rd != 5'd0;
                slot_ready[0] <= 1'b0;
                slot_rd[0]    <= alloc_rd;
                slot_value[0] <= '0;
                for (int unsigned s = 1; s < NUM_STAGES; s++) begin
                    slot_valid[s] <= app_valid[s-1];
                    slot_ready[s] <= app_ready[s-1];
                    slot_rd[s]    <= slot_rd[s-1];
                    slot_value[s] <= app_value[s-1];
                end
            end else begin
                slot_valid <= app_valid;
                slot_ready <= app_ready;
                for (int unsigned s = 0; s < NUM_STAGES; s++) begin
                    slot_value[s] <= app_value[s];
                end
            end
        end
    end

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// Bench for forwarding_scoreboard: directed scenarios plus random traffic against a
// queue-style reference model (apply fills/flushes in place, then shift).
module tb_forwarding_scoreboard;

    localparam int XLEN = 32;
    localparam int NS   = 3;
    localparam int NR   = 2;
    localparam int NF   = 2;
    localparam int SW   = 2;
    localparam int L    = NS - 1;

    logic                 clk;
    logic                 reset;
    logic                 advance;
    logic                 alloc_enable;
    logic [4:0]           alloc_rd;
    logic [NF-1:0]        fill_valid;
    logic [NF*SW-1:0]     fill_slot;
    logic [NF*XLEN-1:0]   fill_value;
    logic [NS-1:0]        flush_mask;
    logic [NR*5-1:0]      rs;
    logic [NR-1:0]        rs_used;
    logic [NR*XLEN-1:0]   rs_value;
    logic [NR*XLEN-1:0]   operand_value;
    logic [NR-1:0]        operand_valid;
    logic                 stall;
    logic                 retire_valid;
    logic [4:0]           retire_rd;
    logic [XLEN-1:0]      retire_value;
    logic                 protocol_error;

    forwarding_scoreboard #(
        .XLEN(XLEN), .NUM_STAGES(NS), .NUM_READ_PORTS(NR), .NUM_FILL_PORTS(NF)
    ) dut (
        .clk(clk), .reset(reset), .advance(advance),
        .alloc_enable(alloc_enable), .alloc_rd(alloc_rd),
        .fill_valid(fill_valid), .fill_slot(fill_slot), .fill_value(fill_value),
        .flush_mask(flush_mask), .rs(rs), .rs_used(rs_used), .rs_value(rs_value),
        .operand_value(operand_value), .operand_valid(operand_valid), .stall(stall),
        .retire_valid(retire_valid), .retire_rd(retire_rd), .retire_value(retire_value),
        .protocol_error(protocol_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit            v;
        bit [4:0]      rd;
        bit            rdy;
        bit [XLEN-1:0] val;
    } ent_t;

    ent_t          m [NS];
    bit            m_err;
    bit            fe [NS];
    bit [XLEN-1:0] fd [NS];
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Which slots receive a usable fill this cycle, and with what data.
    function automatic void derive();
        for (int s = 0; s < NS; s++) begin
            fe[s] = 1'b0;
            fd[s] = '0;
        end
        for (int p = 0; p < NF; p++) begin
            if (fill_valid[p]) begin
                int t;
                t = int'(fill_slot[p*SW +: SW]);
                if (t < NS) begin
                    fe[t] = 1'b1;
                    fd[t] = fill_value[p*XLEN +: XLEN];
                end
            end
        end
        for (int s = 0; s < NS; s++)
            fe[s] = fe[s] && m[s].v && !flush_mask[s];
    endfunction

    task automatic check_outputs();
        bit            est;
        bit            er;
        bit [4:0]      erd;
        bit [XLEN-1:0] erv;
        derive();
        est = 1'b0;
        for (int p = 0; p < NR; p++) begin
            bit [4:0]      r;
            bit            ev;
            bit [XLEN-1:0] eval;
            r    = rs[p*5 +: 5];
            ev   = 1'b1;
            eval = rs_value[p*XLEN +: XLEN];
            if (r != 5'd0) begin
                for (int s = 0; s < NS; s++) begin
                    if (m[s].v && !flush_mask[s] && m[s].rd == r) begin
                        if (m[s].rdy)  eval = m[s].val;
                        else if (fe[s]) eval = fd[s];
                        else begin ev = 1'b0; eval = '0; end
                        break;
                    end
                end
            end
            est = est | (rs_used[p] && !ev);
            chk($sformatf("operand_valid[%0d]", p), operand_valid[p], ev);
            chk($sformatf("operand_value[%0d]", p), operand_value[p*XLEN +: XLEN], eval);
        end
        er  = advance && m[L].v && !flush_mask[L] && (m[L].rdy || fe[L]);
        erd = er ? m[L].rd : 5'd0;
        erv = er ? (fe[L] ? fd[L] : m[L].val) : '0;
        chk("stall", stall, est);
        chk("retire_valid", retire_valid, er);
        chk("retire_rd", retire_rd, erd);
        chk("retire_value", retire_value, erv);
        chk("protocol_error", protocol_error, m_err);
    endtask

    task automatic model_update();
        if (reset) begin
            for (int s = 0; s < NS; s++) m[s] = '{1'b0, 5'd0, 1'b0, '0};
            m_err = 1'b0;
        end else begin
            derive();
            for (int s = 0; s < NS; s++) begin
                if (flush_mask[s]) m[s].v = 1'b0;
                else if (fe[s]) begin
                    m[s].rdy = 1'b1;
                    m[s].val = fd[s];
                end
            end
            if (advance) begin
                if (m[L].v && !m[L].rdy) m_err = 1'b1;
                for (int s = NS - 1; s > 0; s--) m[s] = m[s-1];
                m[0] = '{(alloc_enable && alloc_rd != 5'd0), alloc_rd, 1'b0, '0};
            end
        end
    endtask

    task automatic clr();
        reset = 0; advance = 0; alloc_enable = 0; alloc_rd = '0;
        fill_valid = '0; fill_slot = '0; fill_value = '0; flush_mask = '0;
        rs = '0; rs_used = '0; rs_value = '0;
    endtask

    task automatic sample();
        #1;
        check_outputs();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        clr();
    endtask

    task automatic step();
        sample();
        tick();
    endtask

    task automatic do_fill(input int p, input int slot, input logic [XLEN-1:0] v);
        fill_valid[p] = 1'b1;
        fill_slot[p*SW +: SW] = SW'(slot);
        fill_value[p*XLEN +: XLEN] = v;
    endtask

    task automatic do_rs(input int p, input logic [4:0] r, input logic [XLEN-1:0] v);
        rs[p*5 +: 5] = r;
        rs_used[p] = 1'b1;
        rs_value[p*XLEN +: XLEN] = v;
    endtask

    task automatic do_reset();
        clr();
        reset = 1;
        tick();
    endtask

    initial begin
        clr();
        reset = 1;
        @(posedge clk);
        model_update();
        #1;
        clr();
        sample();
        chk("reset_retire_valid", retire_valid, 1'b0);
        chk("reset_protocol_error", protocol_error, 1'b0);
        tick();

        // Back-to-back dependency
        alloc_enable = 1; alloc_rd = 5'd5; advance = 1;
        step();
        advance = 1; do_fill(0, 0, 32'h11); do_rs(0, 5'd5, 32'hDEAD);
        sample();
        chk("b2b_fillthrough_valid", operand_valid[0], 1'b1);
        chk("b2b_fillthrough_value", operand_value[XLEN-1:0], 32'h11);
        tick();
        advance = 1; do_rs(0, 5'd5, 32'hDEAD);
        sample();
        chk("b2b_state_value", operand_value[XLEN-1:0], 32'h11);
        tick();
        advance = 1;
        sample();
        chk("b2b_retire_valid", retire_valid, 1'b1);
        chk("b2b_retire_rd", retire_rd, 5'd5);
        chk("b2b_retire_value", retire_value, 32'h11);
        tick();

        // Load-use
        do_reset();
        alloc_enable = 1; alloc_rd = 5'd7; advance = 1;
        step();
        for (int c = 0; c < 2; c++) begin
            advance = 1; do_rs(1, 5'd7, 32'h1234);
            sample();
            chk("loaduse_stall", stall, 1'b1);
            tick();
        end
        advance = 1; do_rs(1, 5'd7, 32'h1234); do_fill(1, 2, 32'hCAFE);
        sample();
        chk("loaduse_fill_valid", operand_valid[1], 1'b1);
        chk("loaduse_fill_value", operand_value[2*XLEN-1:XLEN], 32'hCAFE);
        chk("loaduse_no_stall", stall, 1'b0);
        tick();

        // Youngest producer wins
        do_reset();
        alloc_enable = 1; alloc_rd = 5'd3; advance = 1; step();
        advance = 1; do_fill(0, 0, 32'hB); step();
        alloc_enable = 1; alloc_rd = 5'd3; advance = 1; step();
        do_fill(1, 0, 32'hA); step();
        do_rs(0, 5'd3, 32'h0);
        sample();
        chk("youngest_value", operand_value[XLEN-1:0], 32'hA);
        tick();
        do_rs(0, 5'd3, 32'h0); flush_mask = 3'b001;
        sample();
        chk("youngest_flushed_value", operand_value[XLEN-1:0], 32'hB);
        tick();

        // x0 and bubbles
        do_reset();
        alloc_enable = 1; alloc_rd = 5'd0; advance = 1;
        do_rs(0, 5'd0, 32'h99);
        sample();
        chk("x0_value", operand_value[XLEN-1:0], 32'h99);
        chk("x0_valid", operand_valid[0], 1'b1);
        tick();
        for (int c = 0; c < 3; c++) begin
            advance = 1; do_rs(1, 5'd0, 32'h77);
            sample();
            chk("bubble_no_retire", retire_valid, 1'b0);
            tick();
        end

        // Protocol error, then reset mid-flight
        do_reset();
        alloc_enable = 1; alloc_rd = 5'd9; advance = 1; step();
        advance = 1; step();
        advance = 1; step();
        advance = 1;
        sample();
        chk("perr_no_retire", retire_valid, 1'b0);
        tick();
        for (int c = 0; c < 3; c++) begin
            alloc_enable = 1; alloc_rd = 5'd9; advance = (c == 0);
            sample();
            chk("perr_sticky", protocol_error, 1'b1);
            tick();
        end
        reset = 1; do_fill(0, 0, 32'h55); step();
        do_rs(0, 5'd9, 32'h3131);
        sample();
        chk("reset_cleared_slot", operand_value[XLEN-1:0], 32'h3131);
        chk("reset_cleared_perr", protocol_error, 1'b0);
        tick();

        // Hold with advance low
        alloc_enable = 1; alloc_rd = 5'd4; advance = 1; step();
        advance = 1; step();
        do_fill(0, 1, 32'h42); step();
        for (int c = 0; c < 3; c++) begin
            do_rs(0, 5'd4, 32'h0);
            sample();
            chk("hold_value", operand_value[XLEN-1:0], 32'h42);
            tick();
        end
        advance = 1; step();
        advance = 1;
        sample();
        chk("hold_retire_rd", retire_rd, 5'd4);
        chk("hold_retire_value", retire_value, 32'h42);
        tick();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            reset        = ($urandom_range(0, 99) < 2);
            advance      = ($urandom_range(0, 9) < 6);
            alloc_enable = 1'($urandom_range(0, 1));
            alloc_rd     = 5'($urandom_range(0, 7));
            for (int p = 0; p < NF; p++) begin
                fill_valid[p]              = ($urandom_range(0, 2) == 0);
                fill_slot[p*SW +: SW]      = SW'($urandom_range(0, 3));
                fill_value[p*XLEN +: XLEN] = $urandom;
            end
            for (int s = 0; s < NS; s++) flush_mask[s] = ($urandom_range(0, 7) == 0);
            for (int p = 0; p < NR; p++) begin
                rs[p*5 +: 5]             = 5'($urandom_range(0, 7));
                rs_used[p]               = 1'($urandom_range(0, 1));
                rs_value[p*XLEN +: XLEN] = $urandom;
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
